// File: rtl/fwd_pkg.sv
// +----------------------------------------------------------------------+
// | fwd_pkg : shared types for the forwarding / hazard unit              |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package fwd_pkg;

   // Slot rd field is sized for the widest supported register address.
   localparam int c_RD_W = 8;

   typedef enum logic [1:0] {
      FW_RF      = 2'b00,
      FW_MEM_LD  = 2'b01,
      FW_MEM_ALU = 2'b10,
      FW_WB      = 2'b11
   } fw_sel_e;

   typedef struct packed {
      logic              valid;
      logic [c_RD_W-1:0] rd;
      logic              regwrite;
      logic              memtoreg;
   } fwd_slot_t;

   localparam fwd_slot_t c_SLOT_EMPTY = '0;

endpackage

`default_nettype wire

// File: rtl/fwd_src_match.sv
// +----------------------------------------------------------------------+
// | fwd_src_match : forwarding select for one EX source operand          |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module fwd_src_match
   import fwd_pkg::*;
#(
   parameter int REG_AW = 5
)(
   input  logic [REG_AW-1:0] rs,
   input  fwd_slot_t         mem_slot,
   input  fwd_slot_t         wb_slot,
   output fw_sel_e           sel
);

   logic [c_RD_W-1:0] w_rs;
   logic              w_unused_wb;

   assign w_rs        = c_RD_W'(rs);
   assign w_unused_wb = wb_slot.memtoreg;

   // x0 is hard-wired zero; MEM is the younger producer and wins over WB.
   always_comb begin
      sel = FW_RF;
      if (w_rs != '0) begin
         if (mem_slot.valid && mem_slot.regwrite && (mem_slot.rd == w_rs)) begin
            sel = mem_slot.memtoreg ? FW_MEM_LD : FW_MEM_ALU;
         end else if (wb_slot.valid && wb_slot.regwrite && (wb_slot.rd == w_rs)) begin
            sel = FW_WB;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
// +----------------------------------------------------------------------+
// | fwd_hazard_unit : shadow EX/MEM/WB pipeline producing forwarding     |
// |                   selects, load-use bubbles, mem stall and timeout   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int REG_AW         = 5,
   parameter int NUM_SRC        = 2,
   parameter bit LOAD_USE_STALL = 1'b0,
   parameter int MEM_TIMEOUT    = 64
)(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      id_valid,
   input  logic [NUM_SRC*REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0]         id_rd,
   input  logic                      id_regwrite,
   input  logic                      id_memtoreg,
   input  logic                      flush,
   input  logic                      mem_ready,
   output logic [2*NUM_SRC-1:0]      fw_sel,
   output logic                      stall,
   output logic                      bubble,
   output logic                      mem_timeout
);

   fwd_slot_t                 r_ex;
   fwd_slot_t                 r_mem;
   fwd_slot_t                 r_wb;
   logic [NUM_SRC*REG_AW-1:0] r_ex_rs;

   fwd_slot_t                 w_id_slot;
   logic [NUM_SRC-1:0]        w_src_hit;
   logic                      w_mem_stall;
   logic                      w_lu_hit;
   logic                      w_bubble;
   logic                      w_timeout;

   always_comb begin
      w_id_slot          = c_SLOT_EMPTY;
      w_id_slot.valid    = id_valid & ~flush;
      w_id_slot.rd       = c_RD_W'(id_rd);
      w_id_slot.regwrite = id_regwrite;
      w_id_slot.memtoreg = id_memtoreg;
   end

   assign w_mem_stall = r_mem.valid & r_mem.memtoreg & r_mem.regwrite & ~mem_ready;

   generate
      for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
         fw_sel_e w_sel;

         assign w_src_hit[i] = (c_RD_W'(id_rs[i*REG_AW +: REG_AW]) == r_ex.rd);

         fwd_src_match #(
            .REG_AW (REG_AW)
         ) u_match (
            .rs       (r_ex_rs[i*REG_AW +: REG_AW]),
            .mem_slot (r_mem),
            .wb_slot  (r_wb),
            .sel      (w_sel)
         );

         assign fw_sel[2*i +: 2] = r_ex.valid ? w_sel : FW_RF;
      end
   endgenerate

   assign w_lu_hit = LOAD_USE_STALL & id_valid & r_ex.valid & r_ex.memtoreg &
                     r_ex.regwrite & (r_ex.rd != '0) & (|w_src_hit);
   assign w_bubble = w_lu_hit & ~w_mem_stall;

   assign stall       = w_mem_stall;
   assign bubble      = w_bubble;
   assign mem_timeout = w_timeout & rst_n;

   // A stall freezes EX and MEM (flush included); WB drains so nothing is
   // forwarded twice from a retired slot.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ex    <= c_SLOT_EMPTY;
         r_mem   <= c_SLOT_EMPTY;
         r_wb    <= c_SLOT_EMPTY;
         r_ex_rs <= '0;
      end else if (w_mem_stall) begin
         r_wb <= c_SLOT_EMPTY;
      end else begin
         r_wb  <= r_mem;
         r_mem <= r_ex;
         if (w_bubble) begin
            r_ex <= c_SLOT_EMPTY;
         end else begin
            r_ex    <= w_id_slot;
            r_ex_rs <= id_rs;
         end
      end
   end

   generate
      if (MEM_TIMEOUT > 0) begin : g_timeout
         localparam int c_CNT_W = $clog2(MEM_TIMEOUT + 1);

         logic [c_CNT_W-1:0] r_cnt;
         logic               w_hit;

         // Pulse on the MEM_TIMEOUT-th consecutive stall cycle, then restart.
         assign w_hit = w_mem_stall && (r_cnt == c_CNT_W'(MEM_TIMEOUT - 1));

         always_ff @(posedge clk) begin
            if (!rst_n || !w_mem_stall || w_hit) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= r_cnt + c_CNT_W'(1);
            end
         end

         assign w_timeout = w_hit;
      end else begin : g_no_timeout
         assign w_timeout = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// +----------------------------------------------------------------------+
// | tb_fwd_hazard_unit : scoreboard bench, forwarding (dut0) and         |
// |                      load-use bubble (dut1) configurations           |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fwd_hazard_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   int         cyc = 0;
   int         n_tests = 0;
   int         n_fail = 0;

   logic       id_valid    [2];
   logic [9:0] id_rs       [2];
   logic [4:0] id_rd       [2];
   logic       id_regwrite [2];
   logic       id_memtoreg [2];
   logic       flush       [2];
   logic       mem_ready   [2];

   logic [3:0] fw_sel0, fw_sel1;
   logic       stall0, stall1, bubble0, bubble1, to0, to1;

   typedef struct {
      int         cyc;
      int         d;
      string      nm;
      logic [3:0] fw;
      logic       st;
      logic       bb;
      logic       to;
   } exp_t;

   exp_t q[$];
   exp_t e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fwd_hazard_unit #(
      .REG_AW(5), .NUM_SRC(2), .LOAD_USE_STALL(1'b0), .MEM_TIMEOUT(8)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid[0]), .id_rs(id_rs[0]),
      .id_rd(id_rd[0]), .id_regwrite(id_regwrite[0]), .id_memtoreg(id_memtoreg[0]),
      .flush(flush[0]), .mem_ready(mem_ready[0]), .fw_sel(fw_sel0),
      .stall(stall0), .bubble(bubble0), .mem_timeout(to0)
   );

   fwd_hazard_unit #(
      .REG_AW(5), .NUM_SRC(2), .LOAD_USE_STALL(1'b1), .MEM_TIMEOUT(8)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid[1]), .id_rs(id_rs[1]),
      .id_rd(id_rd[1]), .id_regwrite(id_regwrite[1]), .id_memtoreg(id_memtoreg[1]),
      .flush(flush[1]), .mem_ready(mem_ready[1]), .fw_sel(fw_sel1),
      .stall(stall1), .bubble(bubble1), .mem_timeout(to1)
   );

   // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
   always @(negedge clk) begin
      if (rst_n && (fw_sel1[1:0] == 2'b01 || fw_sel1[3:2] == 2'b01)) begin
         n_tests++;
         n_fail++;
         $display("FAIL no_ld_sel_dut1: cycle %0d fw_sel=%b, select 01 not allowed", cyc, fw_sel1);
      end
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         logic [3:0] a_fw;
         logic       a_st, a_bb, a_to;
         e = q.pop_front();
         n_tests++;
         a_fw = (e.d == 0) ? fw_sel0 : fw_sel1;
         a_st = (e.d == 0) ? stall0  : stall1;
         a_bb = (e.d == 0) ? bubble0 : bubble1;
         a_to = (e.d == 0) ? to0     : to1;
         if (e.cyc < cyc) begin
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.nm, e.cyc, cyc);
         end else if (a_fw !== e.fw || a_st !== e.st || a_bb !== e.bb || a_to !== e.to) begin
            n_fail++;
            $display("FAIL %s: dut%0d cyc %0d got fw=%b st=%b bb=%b to=%b, expected fw=%b st=%b bb=%b to=%b",
                     e.nm, e.d, cyc, a_fw, a_st, a_bb, a_to, e.fw, e.st, e.bb, e.to);
         end
      end
   end

   // Drive one cycle on dut d (the other idles) and queue its expected outputs.
   task automatic step(input int d, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mt, input logic fl,
                       input logic mr, input bit chk, input string nm, input logic [3:0] efw,
                       input logic est, input logic ebb, input logic eto);
      exp_t x;
      for (int k = 0; k < 2; k++) begin
         id_valid[k]  = 1'b0;
         flush[k]     = 1'b0;
         mem_ready[k] = 1'b1;
      end
      id_valid[d]    = v;
      id_rs[d]       = {rs2, rs1};
      id_rd[d]       = rd;
      id_regwrite[d] = rw;
      id_memtoreg[d] = mt;
      flush[d]       = fl;
      mem_ready[d]   = mr;
      if (chk) begin
         x.cyc = cyc; x.d = d; x.nm = nm;
         x.fw = efw; x.st = est; x.bb = ebb; x.to = eto;
         q.push_back(x);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int d, input logic mr, input string nm, input logic [3:0] efw,
                       input logic est, input logic ebb, input logic eto);
      step(d, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, mr, 1'b1, nm, efw, est, ebb, eto);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         id_valid[k] = 1'b0; id_rs[k] = '0; id_rd[k] = '0; id_regwrite[k] = 1'b0;
         id_memtoreg[k] = 1'b0; flush[k] = 1'b0; mem_ready[k] = 1'b1;
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "", 4'b0000, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "", 4'b0000, 0, 0, 0);
      rst_n = 1'b1;

      // ALU RAW chain and x0 handling
      step(0, 1, 1, 2, 5, 1, 0, 0, 1, 1, "reset_state",  4'b0000, 0, 0, 0);
      step(0, 1, 5, 4, 6, 1, 0, 0, 1, 1, "alu_none",     4'b0000, 0, 0, 0);
      step(0, 1, 3, 5, 7, 1, 0, 0, 1, 1, "alu_raw_mem",  4'b0010, 0, 0, 0);
      step(0, 1, 1, 1, 0, 1, 0, 0, 1, 1, "alu_raw_wb",   4'b1100, 0, 0, 0);
      step(0, 1, 0, 0, 8, 1, 0, 0, 1, 1, "rd_x0_prod",   4'b0000, 0, 0, 0);
      idle(0, 1, "rs_x0_never_fwd", 4'b0000, 0, 0, 0);

      // Double hit, WB-only hit, non-writing producer
      step(0, 1, 0, 0, 7, 1, 0, 0, 1, 1, "dbl_ex_inv",   4'b0000, 0, 0, 0);
      step(0, 1, 0, 0, 7, 1, 0, 0, 1, 0, "",             4'b0000, 0, 0, 0);
      step(0, 1, 7, 9, 10, 1, 0, 0, 1, 0, "",            4'b0000, 0, 0, 0);
      step(0, 1, 9, 7, 12, 1, 0, 0, 1, 1, "dbl_mem_wins", 4'b0010, 0, 0, 0);
      step(0, 1, 12, 0, 13, 0, 0, 0, 1, 1, "wb_only",    4'b1100, 0, 0, 0);
      step(0, 1, 13, 0, 14, 1, 0, 0, 1, 1, "rw_mem",     4'b0010, 0, 0, 0);
      idle(0, 1, "no_regwrite_fwd", 4'b0000, 0, 0, 0);

      // Memory stall with flush held during it
      step(0, 1, 1, 0, 3, 1, 1, 0, 1, 1, "ld_issue",       4'b0000, 0, 0, 0);
      step(0, 1, 3, 1, 4, 1, 0, 0, 1, 1, "ld_in_ex",       4'b0000, 0, 0, 0);
      step(0, 1, 4, 3, 5, 1, 0, 0, 0, 1, "mstall_1",       4'b0001, 1, 0, 0);
      step(0, 1, 4, 3, 5, 1, 0, 1, 0, 1, "mstall_2_flush", 4'b0001, 1, 0, 0);
      step(0, 1, 4, 3, 5, 1, 0, 1, 0, 1, "mstall_3_flush", 4'b0001, 1, 0, 0);
      step(0, 1, 4, 3, 5, 1, 0, 0, 0, 1, "mstall_4",       4'b0001, 1, 0, 0);
      step(0, 1, 4, 3, 5, 1, 0, 0, 1, 1, "mstall_release", 4'b0001, 0, 0, 0);
      idle(0, 1, "post_stall_fwd", 4'b1110, 0, 0, 0);

      // Timeout: 20 stall cycles, pulses on 8 and 16
      step(0, 1, 0, 0, 3, 1, 1, 0, 1, 1, "to_ld_issue", 4'b0000, 0, 0, 0);
      idle(0, 1, "to_ld_ex", 4'b0000, 0, 0, 0);
      for (int k = 1; k <= 20; k++) idle(0, 0, "to_stall", 4'b0000, 1, 0, (k == 8 || k == 16));
      step(0, 1, 0, 0, 9, 1, 1, 0, 1, 1, "to_release", 4'b0000, 0, 0, 0);
      idle(0, 1, "to_ld2_ex", 4'b0000, 0, 0, 0);
      for (int k = 1; k <= 8; k++) idle(0, 0, "to_restart", 4'b0000, 1, 0, (k == 8));
      idle(0, 0, "to_wrap", 4'b0000, 1, 0, 0);

      // Reset mid-stall
      rst_n = 1'b0;
      idle(0, 0, "rst_cycle", 4'b0000, 1, 0, 0);
      rst_n = 1'b1;
      idle(0, 0, "rst_mid_stall", 4'b0000, 0, 0, 0);

      // Flush kills the entering instruction
      step(0, 1, 0, 0, 20, 1, 0, 1, 1, 1, "flush_issue",  4'b0000, 0, 0, 0);
      step(0, 1, 20, 0, 21, 1, 0, 0, 1, 1, "flush_ex_inv", 4'b0000, 0, 0, 0);
      idle(0, 1, "flush_no_fwd", 4'b0000, 0, 0, 0);

      // Load-use bubble (dut1)
      step(1, 1, 5, 0, 3, 1, 1, 0, 1, 1, "lu_issue",        4'b0000, 0, 0, 0);
      step(1, 1, 3, 1, 4, 1, 0, 0, 1, 1, "lu_bubble",       4'b0000, 0, 1, 0);
      step(1, 1, 3, 1, 4, 1, 0, 0, 1, 1, "lu_after_bubble", 4'b0000, 0, 0, 0);
      idle(1, 1, "lu_fwd_wb", 4'b0011, 0, 0, 0);

      // Stall and load-use together: stall wins, bubble follows release
      step(1, 1, 0, 0, 6, 1, 1, 0, 1, 1, "sl_ld6",         4'b0000, 0, 0, 0);
      step(1, 1, 0, 0, 7, 1, 1, 0, 1, 1, "sl_ld7",         4'b0000, 0, 0, 0);
      step(1, 1, 7, 0, 8, 1, 0, 0, 0, 1, "stall_beats_lu", 4'b0000, 1, 0, 0);
      step(1, 1, 7, 0, 8, 1, 0, 0, 1, 1, "lu_after_stall", 4'b0000, 0, 1, 0);
      step(1, 1, 7, 0, 8, 1, 0, 0, 1, 1, "lu_done",        4'b0000, 0, 0, 0);
      idle(1, 1, "lu2_fwd_wb", 4'b0011, 0, 0, 0);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
